// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: widths, FSM states and fetch queue entry.
package fetch_pkg;
    localparam int PC_W   = 16;
    localparam int INST_W = 16;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_STALL
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: DEPTH-entry synchronous FIFO of {pc, inst} with flush.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: none internally; the producer must never push when full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output entry_t                 head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Flush wins over a same-cycle push: that word belongs to the old stream.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// PC generation and in-order imem fetch into a small queue; FETCH_PERF_CNT_EN adds perf counters.
// Latency: imem_addr follows a redirect one cycle after the pulse; words reach decode the cycle after rvalid.
// Backpressure: requests are credit-limited by queue space and MAX_OUTST; decode stalls via inst_ready.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          PC_STEP   = 1,
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] branchpc,
    input  logic        isbranchtaken,
    input  logic        fetch_stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    input  logic        inst_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
    output logic [31:0] perf_stall
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [OW-1:0]   outst;
    logic [OW-1:0]   outst_next;
    logic [OW-1:0]   drop;
    logic [PC_W-1:0] tag_mem [MAX_OUTST];
    logic [TW-1:0]   tag_wr;
    logic [TW-1:0]   tag_rd;
    logic [CW-1:0]   count;
    entry_t          head;
    entry_t          push_entry;
    logic            gnt_fire;
    logic            drop_word;
    logic            push;
    logic            pop;
    logic            not_empty;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] ptr);
        return (32'(ptr) == MAX_OUTST - 1) ? '0 : ptr + TW'(1);
    endfunction

    // Credit check counts in-flight words as already occupying queue slots.
    assign imem_req   = (state == S_RUN) && !isbranchtaken
                        && (32'(outst) < MAX_OUTST)
                        && (32'(count) + 32'(outst) < DEPTH);
    assign imem_addr  = pc;
    assign gnt_fire   = imem_req && imem_gnt;
    assign drop_word  = imem_rvalid && (drop != '0);
    assign push       = imem_rvalid && !drop_word && !isbranchtaken;
    assign outst_next = outst + OW'(gnt_fire) - OW'(imem_rvalid);
    assign push_entry = '{pc: tag_mem[tag_rd], inst: imem_rdata};

    assign not_empty  = (count != '0);
    assign inst_valid = not_empty && !isbranchtaken;
    assign pop        = inst_valid && inst_ready;
    assign inst       = not_empty ? head.inst : '0;
    assign inst_pc    = not_empty ? head.pc : '0;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (isbranchtaken),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .head       (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_BOOT;
            pc     <= RESET_PC;
            outst  <= '0;
            drop   <= '0;
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            case (state)
                S_BOOT:  state <= S_RUN;
                S_RUN:   if (fetch_stall) state <= S_STALL;
                S_STALL: if (!fetch_stall) state <= S_RUN;
                default: state <= S_BOOT;
            endcase

            outst <= outst_next;
            // Tag FIFO is never flushed: stale responses still return and must pop their tag.
            if (gnt_fire) begin
                tag_mem[tag_wr] <= pc;
                tag_wr          <= tag_next(tag_wr);
            end
            if (imem_rvalid) begin
                tag_rd <= tag_next(tag_rd);
            end

            if (isbranchtaken) begin
                pc   <= branchpc;
                drop <= outst_next;
            end else begin
                if (gnt_fire) begin
                    pc <= pc + PC_W'(PC_STEP);
                end
                if (drop_word) begin
                    drop <= drop - OW'(1);
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (imem_rvalid && !push && (perf_dropped != '1)) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
            if ((state == S_STALL) && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model and imem responder.
module tb_fetch_unit;
    localparam int DEPTH     = 4;
    localparam int MAX_OUTST = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] branchpc = '0;
    logic        isbranchtaken = 1'b0;
    logic        fetch_stall = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (16'h0000),
        .PC_STEP   (1),
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .branchpc      (branchpc),
        .isbranchtaken (isbranchtaken),
        .fetch_stall   (fetch_stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_dropped  (perf_dropped),
        .perf_stall    (perf_stall)
`endif
    );

    // Reference model: words waiting for decode, and requests in flight.
    typedef struct {
        logic [15:0] addr;
        bit          stale;
        int          cyc;
    } flight_t;

    flight_t     inflight[$];
    logic [31:0] ref_q[$];
    logic [15:0] m_pc = 16'h0000;
    bit          m_boot = 1'b1;
    bit          m_stall = 1'b0;
    bit          just_reset = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    int pg = 0, prv = 0, prd = 0, pst = 0, pbr = 0;
    bit lat1 = 1'b1;
    logic [15:0] br_targets [4] = '{16'h0040, 16'hFFFE, 16'h0100, 16'h7FF0};

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle(input bit rst);
        bit      exp_req;
        bit      exp_valid;
        flight_t f;
        @(posedge clk);
        #1;
        reset         = rst;
        isbranchtaken = ($urandom_range(99) < pbr);
        branchpc      = br_targets[$urandom_range(3)];
        fetch_stall   = ($urandom_range(99) < pst);
        imem_gnt      = ($urandom_range(99) < pg);
        inst_ready    = ($urandom_range(99) < prd);
        imem_rvalid   = !rst && (inflight.size() > 0) && (inflight[0].cyc < cyc)
                        && (lat1 || ($urandom_range(99) < prv));
        imem_rdata    = imem_rvalid ? mem_word(inflight[0].addr) : 16'($urandom);
        #4;

        exp_req   = !m_boot && !m_stall && !isbranchtaken && (inflight.size() < MAX_OUTST)
                    && (ref_q.size() + inflight.size() < DEPTH);
        exp_valid = (ref_q.size() != 0) && !isbranchtaken;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("inst_valid", 32'(inst_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("inst", 32'(inst), 32'(ref_q[0][31:16]));
            check("inst_pc", 32'(inst_pc), 32'(ref_q[0][15:0]));
        end
        if (just_reset) begin
            check("rst_inst", 32'(inst), 32'h0);
            check("rst_inst_pc", 32'(inst_pc), 32'h0);
        end

        if (rst) begin
            m_pc = 16'h0000;
            ref_q.delete();
            inflight.delete();
            m_boot     = 1'b1;
            m_stall    = 1'b0;
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            if (exp_valid && inst_ready) begin
                void'(ref_q.pop_front());
            end
            if (imem_rvalid) begin
                f = inflight.pop_front();
                if (!f.stale && !isbranchtaken) begin
                    ref_q.push_back({imem_rdata, f.addr});
                end
            end
            if (exp_req && imem_gnt) begin
                inflight.push_back('{addr: m_pc, stale: 1'b0, cyc: cyc});
                m_pc = m_pc + 16'd1;
            end
            if (isbranchtaken) begin
                ref_q.delete();
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                m_pc = branchpc;
            end
            if (m_boot) m_boot = 1'b0;
            else        m_stall = fetch_stall;
        end
        cyc++;
    endtask

    task automatic set_knobs(input int g, input int rv, input int rd, input int st,
                             input int br, input bit l1);
        pg = g; prv = rv; prd = rd; pst = st; pbr = br; lat1 = l1;
    endtask

    initial begin
        // Reset, then straight-line fetch with single-cycle memory.
        set_knobs(100, 100, 100, 0, 0, 1'b1);
        repeat (2) cycle(1'b1);
        repeat (30) cycle(1'b0);
        // Decode blocked: queue fills and requests stop, then drains in order.
        set_knobs(100, 100, 0, 0, 0, 1'b1);
        repeat (15) cycle(1'b0);
        set_knobs(100, 100, 100, 0, 0, 1'b1);
        repeat (10) cycle(1'b0);
        // Redirects with variable memory latency and random decode readiness.
        set_knobs(70, 50, 70, 0, 8, 1'b0);
        repeat (400) cycle(1'b0);
        // Stall episodes mixed with in-flight responses.
        set_knobs(100, 60, 80, 40, 0, 1'b0);
        repeat (300) cycle(1'b0);
        // Everything at once, including wrap targets and occasional resets.
        set_knobs(80, 100, 60, 15, 10, 1'b1);
        repeat (300) cycle($urandom_range(99) < 2);
        // Reset with a full queue and requests still outstanding.
        set_knobs(100, 30, 0, 0, 0, 1'b0);
        repeat (12) cycle(1'b0);
        cycle(1'b1);
        set_knobs(100, 100, 100, 0, 0, 1'b1);
        repeat (40) cycle(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
